// File: rtl/bcd_display_scan_ctrl.sv
// Scans an 8-bit binary value as three BCD digits onto a multiplexed 7-seg display.
// Latency: 2 edges from load acceptance to new digits; SCAN_DIV cycles per digit slot.
// Backpressure: load_ready low only during the single CONV cycle; clear overrides loads.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero hundreds/tens slots.

module bin_to_bcd_8bit (
  input  logic [7:0] bin,
  output logic [3:0] unidade,
  output logic [3:0] dezena,
  output logic [3:0] centena
);

  logic [19:0] sh;

  // Double-dabble: add 3 to any BCD nibble >= 5 before each left shift.
  always_comb begin
    sh = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = {sh[18:0], 1'b0};
    end
  end

  assign unidade = sh[11:8];
  assign dezena  = sh[15:12];
  assign centena = sh[19:16];

endmodule

module bcd_display_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value_in,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic       clear,
  output logic [3:0] digit_out,
  output logic [2:0] anode_out,
  output logic       busy_out
);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  hold_q;
  logic [3:0]  units_q, tens_q, hund_q;
  logic [3:0]  bcd_units, bcd_tens, bcd_hund;
  logic [19:0] presc_q;
  logic [1:0]  idx_q;
  logic        accept;

  // Only the conversion cycle refuses a new value; clear wins over a load.
  assign load_ready = (state_q != CONV);
  assign accept     = load_valid && load_ready && !clear;
  assign busy_out   = (state_q == CONV);

  bin_to_bcd_8bit u_bcd (
    .bin     (hold_q),
    .unidade (bcd_units),
    .dezena  (bcd_tens),
    .centena (bcd_hund)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: accept -> CONV, CONV always lasts one cycle, clear returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = CONV;
        CONV:    state_d = SHOW;
        SHOW:    if (accept) state_d = CONV;
        default: state_d = IDLE;
      endcase
    end
  end

  // Hold register captures the accepted value for the converter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      hold_q <= 8'd0;
    else if (accept) hold_q <= value_in;
  end

  // Digit registers, prescaler and scan index; old digits stay until the CONV cycle ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      presc_q <= 20'd0;
      idx_q   <= 2'd0;
    end else if (clear) begin
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      presc_q <= 20'd0;
      idx_q   <= 2'd0;
    end else if (state_q == CONV) begin
      units_q <= bcd_units;
      tens_q  <= bcd_tens;
      hund_q  <= bcd_hund;
      presc_q <= 20'd0;
      idx_q   <= 2'd0;
    end else if (state_q == SHOW) begin
      if (presc_q == PRESC_MAX) begin
        presc_q <= 20'd0;
        idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        presc_q <= presc_q + 20'd1;
      end
    end
  end

  // Display drive: blank outside SHOW, otherwise select the indexed digit.
  always_comb begin
    anode_out = 3'b111;
    digit_out = 4'd0;
    if (state_q == SHOW) begin
      case (idx_q)
        2'd0: begin anode_out = 3'b110; digit_out = units_q; end
        2'd1: begin anode_out = 3'b101; digit_out = tens_q;  end
        2'd2: begin anode_out = 3'b011; digit_out = hund_q;  end
        default: begin anode_out = 3'b111; digit_out = 4'd0; end
      endcase
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_q == 2'd2 && hund_q == 4'd0)                   anode_out = 3'b111;
      if (idx_q == 2'd1 && hund_q == 4'd0 && tens_q == 4'd0) anode_out = 3'b111;
`else
`endif
    end
  end

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Scoreboard bench: a value-level model predicts each cycle's display outputs for
// two instances (SCAN_DIV=4 and SCAN_DIV=1) sharing one stimulus stream.
// A negedge monitor pops the prediction and compares every output.

module tb_bcd_display_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] value_in;
  logic       load_valid;
  logic       clear;
  logic       load_ready, busy_out;
  logic [3:0] digit_out;
  logic [2:0] anode_out;
  logic       load_ready1, busy_out1;
  logic [3:0] digit_out1;
  logic [2:0] anode_out1;

  int n_cmp = 0;
  int n_err = 0;

  bcd_display_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load_valid(load_valid),
    .load_ready(load_ready), .clear(clear), .digit_out(digit_out),
    .anode_out(anode_out), .busy_out(busy_out)
  );

  bcd_display_scan_ctrl #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load_valid(load_valid),
    .load_ready(load_ready1), .clear(clear), .digit_out(digit_out1),
    .anode_out(anode_out1), .busy_out(busy_out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] an4;
    logic [3:0] dg4;
    logic [2:0] an1;
    logic [3:0] dg1;
    logic       busy;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  localparam int M_IDLE = 0, M_CONV = 1, M_SHOW = 2;
  int m_mode = M_IDLE;
  int m_held = 0;
  int m_val  = 0;
  int m_t    = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Display the model predicts for a given scan divider.
  function automatic void model_disp(input int d, output logic [2:0] an, output logic [3:0] dg);
    int idx;
    an = 3'b111;
    dg = 4'd0;
    if (m_mode == M_SHOW) begin
      idx = (m_t / d) % 3;
      case (idx)
        0: dg = 4'(m_val % 10);
        1: dg = 4'((m_val / 10) % 10);
        default: dg = 4'(m_val / 100);
      endcase
      an = 3'b111 & ~(3'b001 << idx);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 2 && m_val < 100) an = 3'b111;
      if (idx == 1 && m_val < 10)  an = 3'b111;
`else
`endif
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    model_disp(4, e.an4, e.dg4);
    model_disp(1, e.an1, e.dg1);
    e.busy = (m_mode == M_CONV);
    e.rdy  = (m_mode != M_CONV);
    return e;
  endfunction

  // Reference model: advances on each edge using the inputs seen before it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_held = 0;
      m_val  = 0;
      m_t    = 0;
      exp_q.delete();
      exp_q.push_back(model_exp());
    end else begin
      if (clear) begin
        m_mode = M_IDLE;
        m_val  = 0;
      end else if (m_mode == M_CONV) begin
        m_mode = M_SHOW;
        m_val  = m_held;
        m_t    = 0;
      end else if (load_valid) begin
        m_held = int'(value_in);
        m_mode = M_CONV;
      end else if (m_mode == M_SHOW) begin
        m_t++;
      end
      exp_q.push_back(model_exp());
    end
  end

  // Monitor: compares the DUT outputs against the pending prediction mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("anode_div4", int'(anode_out), int'(e.an4));
      chk("digit_div4", int'(digit_out), int'(e.dg4));
      chk("busy_div4",  int'(busy_out),  int'(e.busy));
      chk("ready_div4", int'(load_ready), int'(e.rdy));
      chk("anode_div1", int'(anode_out1), int'(e.an1));
      chk("digit_div1", int'(digit_out1), int'(e.dg1));
      chk("busy_div1",  int'(busy_out1),  int'(e.busy));
      chk("ready_div1", int'(load_ready1), int'(e.rdy));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers a value and holds it until the handshake completes (bounded).
  task automatic do_load(input logic [7:0] v);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    load_valid = 1'b1;
    value_in   = v;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = load_ready && !clear;
      @(posedge clk);
      #1;
      n++;
    end
    load_valid = 1'b0;
    value_in   = 8'($urandom);
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL load_handshake value %0d: accepted 0 expected 1", v);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    value_in   = 8'd0;
    load_valid = 1'b0;
    clear      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(2);

    // 255 at four cycles per digit: 5,5,2 repeating.
    do_load(8'd255);
    cycles(30);

    // All zeros, exercising leading-zero handling.
    do_load(8'd0);
    cycles(15);

    // Reload during SHOW: 7 keeps scanning until the conversion cycle.
    do_load(8'd7);
    cycles(9);
    do_load(8'd130);
    cycles(20);

    // Clear and load together in SHOW: clear wins, value dropped.
    clear      = 1'b1;
    load_valid = 1'b1;
    value_in   = 8'd99;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    load_valid = 1'b0;
    cycles(4);

    // Reset in the middle of a conversion.
    do_load(8'd42);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_anode", int'(anode_out), 7);
    chk("rst_busy",  int'(busy_out), 0);
    chk("rst_ready", int'(load_ready), 1);
    chk("rst_digit", int'(digit_out), 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cycles(2);

    // 128: units 8, tens 2, hundreds 1 (every cycle on the SCAN_DIV=1 instance).
    do_load(8'd128);
    cycles(20);

    // Random traffic including back-to-back loads and stray clears.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(7, 0) == 0) begin
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
      end
      do_load(8'($urandom));
      cycles($urandom_range(30, 0));
    end

    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
